// File: rtl/arith_mult_acc_pkg.sv
// Shared types and helpers for the product-stream accumulator.
package arith_mult_acc_pkg;

  // Accumulator FSM: waiting for a start-of-packet, or summing an open packet.
  typedef enum logic [0:0] {
    ST_IDLE,
    ST_ACC
  } acc_state_e;

  // Width of a term counter that must represent 0..max_terms inclusive.
  function automatic int unsigned get_cnt_w(input int unsigned max_terms);
    return (max_terms < 1) ? 1 : $clog2(max_terms + 1);
  endfunction

endpackage

// File: rtl/arith_mult_acc.sv
// Packet accumulator fed by the multiplier core: sums consecutive products
// between sop and eop and emits sum, term count, sop side data and overflow.
module arith_mult_acc
  import arith_mult_acc_pkg::*;
#(
  parameter int unsigned OP_W      = 32,
  parameter int unsigned ACC_W     = 48,
  parameter int unsigned MAX_TERMS = 256,
  parameter int unsigned SIDE_W    = 8
) (
  input  logic                              clk,
  input  logic                              a_rst,
  input  logic                              in_avail,
  input  logic [OP_W-1:0]                   in_z,
  input  logic                              in_sop,
  input  logic                              in_eop,
  input  logic [SIDE_W-1:0]                 in_side,
  output logic                              out_avail,
  output logic [ACC_W-1:0]                  out_acc,
  output logic [get_cnt_w(MAX_TERMS)-1:0]   out_cnt,
  output logic [SIDE_W-1:0]                 out_side,
  output logic                              out_ovf,
  output logic                              err_seq
);

  localparam int unsigned   CntW   = get_cnt_w(MAX_TERMS);
  localparam int unsigned   SumW   = ACC_W + 1;
  localparam logic [CntW-1:0] MaxCnt = CntW'(MAX_TERMS);
  localparam logic [CntW-1:0] OneCnt = CntW'(1);

  // Reject parameterisations the datapath cannot represent.
  if (ACC_W < OP_W) begin : gen_chk_acc_w
    $error("arith_mult_acc: ACC_W must be >= OP_W");
  end
  if (MAX_TERMS < 1) begin : gen_chk_max_terms
    $error("arith_mult_acc: MAX_TERMS must be >= 1");
  end
  if (SIDE_W < 1) begin : gen_chk_side_w
    $error("arith_mult_acc: SIDE_W must be >= 1");
  end

  // Packet state.
  acc_state_e          state_q, state_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [SIDE_W-1:0]   side_q, side_d;
  logic                ovf_q, ovf_d;

  // Registered result and error outputs.
  logic                out_avail_q, out_avail_d;
  logic [ACC_W-1:0]    out_acc_q, out_acc_d;
  logic [CntW-1:0]     out_cnt_q, out_cnt_d;
  logic [SIDE_W-1:0]   out_side_q, out_side_d;
  logic                out_ovf_q, out_ovf_d;
  logic                err_seq_q, err_seq_d;

  // One extra bit above the accumulator captures the carry-out of each add.
  logic [ACC_W:0]      z_ext;
  logic [ACC_W:0]      sum;
  logic [ACC_W-1:0]    z_acc;

  assign z_ext = SumW'(in_z);
  assign z_acc = ACC_W'(in_z);
  assign sum   = {1'b0, acc_q} + z_ext;

  // Next-state: packet framing, accumulation and result/error generation.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    side_d      = side_q;
    ovf_d       = ovf_q;
    out_avail_d = 1'b0;
    out_acc_d   = out_acc_q;
    out_cnt_d   = out_cnt_q;
    out_side_d  = out_side_q;
    out_ovf_d   = out_ovf_q;
    err_seq_d   = 1'b0;

    if (in_avail) begin
      unique case (state_q)
        ST_IDLE: begin
          // A continuation beat with no open packet is dropped.
          if (!in_sop) begin
            err_seq_d = 1'b1;
          end
        end
        ST_ACC: begin
          if (in_sop) begin
            // Open packet is abandoned; the sop beat is handled below.
            err_seq_d = 1'b1;
          end else begin
            acc_d = sum[ACC_W-1:0];
            ovf_d = ovf_q | sum[ACC_W];
            if (cnt_q == MaxCnt) begin
              // Term limit exceeded: keep summing, pin the count, flag it.
              ovf_d     = 1'b1;
              err_seq_d = 1'b1;
            end else begin
              cnt_d = cnt_q + OneCnt;
            end
            if (in_eop) begin
              out_avail_d = 1'b1;
              out_acc_d   = acc_d;
              out_cnt_d   = cnt_d;
              out_side_d  = side_q;
              out_ovf_d   = ovf_d;
              state_d     = ST_IDLE;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase

      // Start of packet, from either state.
      if (in_sop) begin
        if (in_eop) begin
          out_avail_d = 1'b1;
          out_acc_d   = z_acc;
          out_cnt_d   = OneCnt;
          out_side_d  = in_side;
          out_ovf_d   = 1'b0;
          state_d     = ST_IDLE;
        end else begin
          acc_d   = z_acc;
          cnt_d   = OneCnt;
          side_d  = in_side;
          ovf_d   = 1'b0;
          state_d = ST_ACC;
        end
      end
    end
  end

  // State and output registers; reset clears everything and drops any open packet.
  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) begin
      state_q     <= ST_IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      side_q      <= '0;
      ovf_q       <= 1'b0;
      out_avail_q <= 1'b0;
      out_acc_q   <= '0;
      out_cnt_q   <= '0;
      out_side_q  <= '0;
      out_ovf_q   <= 1'b0;
      err_seq_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      side_q      <= side_d;
      ovf_q       <= ovf_d;
      out_avail_q <= out_avail_d;
      out_acc_q   <= out_acc_d;
      out_cnt_q   <= out_cnt_d;
      out_side_q  <= out_side_d;
      out_ovf_q   <= out_ovf_d;
      err_seq_q   <= err_seq_d;
    end
  end

  assign out_avail = out_avail_q;
  assign out_acc   = out_acc_q;
  assign out_cnt   = out_cnt_q;
  assign out_side  = out_side_q;
  assign out_ovf   = out_ovf_q;
  assign err_seq   = err_seq_q;

endmodule

// File: tb/tb_arith_mult_acc.sv
// Bench for arith_mult_acc: packet-level reference model checked every cycle,
// directed cases with literal expectations, then randomized traffic.
module tb_arith_mult_acc;

  localparam int unsigned OpW      = 32;
  localparam int unsigned AccW     = 33;
  localparam int unsigned MaxTerms = 4;
  localparam int unsigned SideW    = 8;
  localparam int unsigned CntW     = 3;

  logic             clk      = 1'b0;
  logic             a_rst    = 1'b1;
  logic             in_avail = 1'b0;
  logic [OpW-1:0]   in_z     = '0;
  logic             in_sop   = 1'b0;
  logic             in_eop   = 1'b0;
  logic [SideW-1:0] in_side  = '0;
  logic             out_avail;
  logic [AccW-1:0]  out_acc;
  logic [CntW-1:0]  out_cnt;
  logic [SideW-1:0] out_side;
  logic             out_ovf;
  logic             err_seq;

  int n_vec = 0;
  int n_err = 0;
  bit run_cmp = 1'b0;

  // Expected registered outputs, produced by the model below.
  logic             exp_avail = 1'b0;
  logic [63:0]      exp_acc   = '0;
  logic [63:0]      exp_cnt   = '0;
  logic [SideW-1:0] exp_side  = '0;
  logic             exp_ovf   = 1'b0;
  logic             exp_err   = 1'b0;

  always #5 clk = ~clk;

  arith_mult_acc #(
    .OP_W      (OpW),
    .ACC_W     (AccW),
    .MAX_TERMS (MaxTerms),
    .SIDE_W    (SideW)
  ) dut (
    .clk       (clk),
    .a_rst     (a_rst),
    .in_avail  (in_avail),
    .in_z      (in_z),
    .in_sop    (in_sop),
    .in_eop    (in_eop),
    .in_side   (in_side),
    .out_avail (out_avail),
    .out_acc   (out_acc),
    .out_cnt   (out_cnt),
    .out_side  (out_side),
    .out_ovf   (out_ovf),
    .err_seq   (err_seq)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Packet model: keeps the exact (unbounded) packet sum and term count, and
  // derives wrap, overflow and count saturation only when a result is emitted.
  initial begin : model
    longint unsigned total;
    int              terms;
    bit              open;
    logic [SideW-1:0] pside;
    total = 0;
    terms = 0;
    open  = 1'b0;
    pside = '0;
    forever begin
      @(posedge clk or posedge a_rst);
      if (a_rst) begin
        open      = 1'b0;
        exp_avail = 1'b0;
        exp_acc   = '0;
        exp_cnt   = '0;
        exp_side  = '0;
        exp_ovf   = 1'b0;
        exp_err   = 1'b0;
      end else begin
        exp_avail = 1'b0;
        exp_err   = 1'b0;
        if (in_avail) begin
          if (in_sop) begin
            if (open) exp_err = 1'b1;
            open  = 1'b1;
            total = 64'(in_z);
            terms = 1;
            pside = in_side;
          end else if (!open) begin
            exp_err = 1'b1;
          end else begin
            total = total + 64'(in_z);
            terms = terms + 1;
            if (terms > int'(MaxTerms)) exp_err = 1'b1;
          end
          if (open && in_eop) begin
            exp_avail = 1'b1;
            exp_acc   = total & ((64'd1 << AccW) - 64'd1);
            exp_cnt   = (terms > int'(MaxTerms)) ? 64'(MaxTerms) : 64'(terms);
            exp_side  = pside;
            exp_ovf   = ((total >> AccW) != 0) || (terms > int'(MaxTerms));
            open      = 1'b0;
          end
        end
      end
    end
  end

  // Compare DUT against the model on every falling edge.
  initial begin : compare
    forever begin
      @(negedge clk);
      if (run_cmp) begin
        chk("m_avail", 64'(out_avail), 64'(exp_avail));
        chk("m_err",   64'(err_seq),   64'(exp_err));
        chk("m_acc",   64'(out_acc),   exp_acc);
        chk("m_cnt",   64'(out_cnt),   exp_cnt);
        chk("m_side",  64'(out_side),  64'(exp_side));
        chk("m_ovf",   64'(out_ovf),   64'(exp_ovf));
      end
    end
  end

  task automatic beat(input bit av, input logic [OpW-1:0] z, input bit sop, input bit eop,
                      input logic [SideW-1:0] side);
    @(negedge clk);
    in_avail = av;
    in_z     = z;
    in_sop   = sop;
    in_eop   = eop;
    in_side  = side;
  endtask

  // Idle cycle with junk on the unqualified inputs.
  task automatic tick_idle();
    @(negedge clk);
    in_avail = 1'b0;
    in_z     = $urandom;
    in_sop   = 1'($urandom);
    in_eop   = 1'($urandom);
    in_side  = 8'($urandom);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_avail"}, 64'(out_avail), 64'd0);
    chk({tag, "_acc"},   64'(out_acc),   64'd0);
    chk({tag, "_cnt"},   64'(out_cnt),   64'd0);
    chk({tag, "_side"},  64'(out_side),  64'd0);
    chk({tag, "_ovf"},   64'(out_ovf),   64'd0);
    chk({tag, "_err"},   64'(err_seq),   64'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    in_avail = 1'b0;
    #2 a_rst = 1'b1;
    #1 chk_zero("rst_async");
    @(negedge clk);
    #2 a_rst = 1'b0;
  endtask

  initial begin : stim
    int errs;
    #1 chk_zero("rst_init");
    repeat (2) @(negedge clk);
    #2 a_rst = 1'b0;
    run_cmp = 1'b1;

    // Multi-term packet 3,5,7.
    beat(1, 3, 1, 0, 8'hA5);
    beat(1, 5, 0, 0, 8'h00);
    beat(1, 7, 0, 1, 8'h00);
    tick_idle();
    chk("mt_avail", 64'(out_avail), 64'd1);
    chk("mt_acc",   64'(out_acc),   64'd15);
    chk("mt_cnt",   64'(out_cnt),   64'd3);
    chk("mt_side",  64'(out_side),  64'hA5);
    chk("mt_ovf",   64'(out_ovf),   64'd0);

    // Back-to-back single-term packets.
    beat(1, 1, 1, 1, 8'h01);
    for (int i = 2; i <= 5; i++) begin
      if (i <= 4) beat(1, OpW'(i), 1, 1, SideW'(i));
      else tick_idle();
      chk("b2b_avail", 64'(out_avail), 64'd1);
      chk("b2b_acc",   64'(out_acc),   64'(i - 1));
      chk("b2b_cnt",   64'(out_cnt),   64'd1);
    end
    tick_idle();
    chk("b2b_end", 64'(out_avail), 64'd0);

    // Carry overflow at 33 bits.
    beat(1, 32'hFFFF_FFFF, 1, 0, 8'h3C);
    beat(1, 32'hFFFF_FFFF, 0, 0, 8'h00);
    beat(1, 32'hFFFF_FFFF, 0, 1, 8'h00);
    tick_idle();
    chk("cy_acc", 64'(out_acc), 64'h0_FFFF_FFFD);
    chk("cy_ovf", 64'(out_ovf), 64'd1);
    chk("cy_cnt", 64'(out_cnt), 64'd3);

    // Beat without sop while idle.
    beat(1, 5, 0, 1, 8'h00);
    tick_idle();
    chk("nosop_err",   64'(err_seq),   64'd1);
    chk("nosop_avail", 64'(out_avail), 64'd0);

    // sop arrives as term 2 of an open packet.
    beat(1, 1, 1, 0, 8'h11);
    beat(1, 9, 1, 1, 8'h22);
    tick_idle();
    chk("resop_err",   64'(err_seq),   64'd1);
    chk("resop_avail", 64'(out_avail), 64'd1);
    chk("resop_acc",   64'(out_acc),   64'd9);
    chk("resop_cnt",   64'(out_cnt),   64'd1);
    chk("resop_side",  64'(out_side),  64'h22);

    // Term limit: six unit terms with MAX_TERMS = 4.
    errs = 0;
    for (int i = 1; i <= 6; i++) begin
      beat(1, 1, (i == 1), (i == 6), 8'h44);
      if (i > 1) errs += int'(err_seq);
    end
    tick_idle();
    errs += int'(err_seq);
    chk("lim_avail", 64'(out_avail), 64'd1);
    chk("lim_acc",   64'(out_acc),   64'd6);
    chk("lim_cnt",   64'(out_cnt),   64'd4);
    chk("lim_ovf",   64'(out_ovf),   64'd1);
    chk("lim_errs",  64'(errs),      64'd2);

    // Reset between terms 2 and 3, then a clean packet.
    beat(1, 10, 1, 0, 8'h55);
    beat(1, 20, 0, 0, 8'h00);
    do_reset();
    beat(1, 2, 1, 0, 8'h66);
    beat(1, 2, 0, 1, 8'h00);
    tick_idle();
    chk("prst_acc",  64'(out_acc),  64'd4);
    chk("prst_cnt",  64'(out_cnt),  64'd2);
    chk("prst_side", 64'(out_side), 64'h66);

    // Gaps inside a packet.
    beat(1, 3, 1, 0, 8'h77);
    tick_idle();
    beat(1, 5, 0, 0, 8'h00);
    tick_idle();
    tick_idle();
    beat(1, 7, 0, 1, 8'h00);
    tick_idle();
    chk("gap_avail", 64'(out_avail), 64'd1);
    chk("gap_acc",   64'(out_acc),   64'd15);
    chk("gap_cnt",   64'(out_cnt),   64'd3);
    tick_idle();
    chk("gap_hold", 64'(out_acc), 64'd15);

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 399) == 0) begin
        do_reset();
      end else begin
        beat(($urandom_range(0, 3) != 0),
             ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : 32'($urandom),
             ($urandom_range(0, 4) == 0),
             ($urandom_range(0, 3) == 0),
             8'($urandom));
      end
    end
    tick_idle();
    tick_idle();
    run_cmp = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
